// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface sync_fifo_flags_if #(
    parameter int data_width_p = 8,
    parameter int addr_size_p  = 8
);
    logic                    wr_en;
    logic                    rd_en;
    logic [data_width_p-1:0] data_in;
    logic [data_width_p-1:0] data_out;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [addr_size_p:0]    count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and optional first-word fall-through reads.
module sync_fifo_flags #(
    parameter int data_width_p    = 8,
    parameter int addr_size_p     = 8,
    parameter int mem_depth_p     = 256,
    parameter int afull_thresh_p  = 252,
    parameter int aempty_thresh_p = 4,
    parameter int fwft_p          = 0
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_flags_if.slave   bus
);
    localparam int ptr_w_c = addr_size_p + 1;
    localparam logic [addr_size_p:0] depth_c  = ptr_w_c'(mem_depth_p);
    localparam logic [addr_size_p:0] afull_c  = ptr_w_c'(afull_thresh_p);
    localparam logic [addr_size_p:0] aempty_c = ptr_w_c'(aempty_thresh_p);
    localparam logic [addr_size_p:0] one_c    = ptr_w_c'(1);

    if (mem_depth_p != (2 ** addr_size_p)) begin : g_bad_depth
        $error("sync_fifo_flags: mem_depth_p must equal 2**addr_size_p");
    end
    if ((afull_thresh_p < 1) || (afull_thresh_p > mem_depth_p)) begin : g_bad_afull
        $error("sync_fifo_flags: afull_thresh_p out of range");
    end
    if ((aempty_thresh_p < 0) || (aempty_thresh_p > mem_depth_p - 1)) begin : g_bad_aempty
        $error("sync_fifo_flags: aempty_thresh_p out of range");
    end

    logic [data_width_p-1:0] mem_r [mem_depth_p];
    logic [addr_size_p:0]    wr_ptr_r;
    logic [addr_size_p:0]    rd_ptr_r;
    logic [addr_size_p:0]    count_r;
    logic [data_width_p-1:0] data_out_r;
    logic                    full_r;
    logic                    empty_r;
    logic                    afull_r;
    logic                    aempty_r;
    logic                    overflow_r;
    logic                    underflow_r;

    logic                    wr_accept_s;
    logic                    rd_accept_s;
    logic [addr_size_p:0]    count_next_s;
    logic [addr_size_p:0]    wr_ptr_next_s;
    logic [addr_size_p:0]    rd_ptr_next_s;
    logic [addr_size_p-1:0]  wr_addr_s;
    logic [addr_size_p-1:0]  rd_addr_s;
    logic [addr_size_p-1:0]  rd_addr_next_s;
    logic [data_width_p-1:0] data_next_s;

    assign wr_accept_s    = bus.wr_en & ~full_r;
    assign rd_accept_s    = bus.rd_en & ~empty_r;
    assign wr_addr_s      = wr_ptr_r[addr_size_p-1:0];
    assign rd_addr_s      = rd_ptr_r[addr_size_p-1:0];
    assign rd_addr_next_s = rd_ptr_next_s[addr_size_p-1:0];

    // Next occupancy and pointer values from the accepted operations.
    always_comb begin
        count_next_s  = count_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_next_s = count_r + one_c;
            2'b01:   count_next_s = count_r - one_c;
            default: count_next_s = count_r;
        endcase
        if (wr_accept_s) begin
            wr_ptr_next_s = wr_ptr_r + one_c;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (rd_accept_s) begin
            rd_ptr_next_s = rd_ptr_r + one_c;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Read data selection; in FWFT mode a word being written to the slot the
    // read pointer will sit on next cycle is bypassed straight from data_in.
    always_comb begin
        data_next_s = data_out_r;
        if (fwft_p != 0) begin
            if (wr_accept_s && (rd_addr_next_s == wr_addr_s)) begin
                data_next_s = bus.data_in;
            end else begin
                data_next_s = mem_r[rd_addr_next_s];
            end
        end else begin
            if (rd_accept_s) begin
                data_next_s = mem_r[rd_addr_s];
            end else begin
                data_next_s = data_out_r;
            end
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_addr_s] <= bus.data_in;
        end
    end

    // Pointers, count, registered flags, error pulses and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            data_out_r  <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            data_out_r  <= data_next_s;
            full_r      <= (count_next_s == depth_c);
            empty_r     <= (count_next_s == '0);
            afull_r     <= (count_next_s >= afull_c);
            aempty_r    <= (count_next_s <= aempty_c);
            overflow_r  <= bus.wr_en & full_r;
            underflow_r <= bus.rd_en & empty_r;
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = afull_r;
    assign bus.almost_empty = aempty_r;
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-read instance and an FWFT
// instance share the same stimulus; depth 8, almost_full 6, almost_empty 1.
module tb_sync_fifo_flags;
    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    int         check_cnt;
    int         error_cnt;
    logic [7:0] exp_q [7];

    sync_fifo_flags_if #(.data_width_p(8), .addr_size_p(3)) bus_a ();
    sync_fifo_flags_if #(.data_width_p(8), .addr_size_p(3)) bus_b ();

    assign bus_a.wr_en   = wr_en;
    assign bus_a.rd_en   = rd_en;
    assign bus_a.data_in = data_in;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.rd_en   = rd_en;
    assign bus_b.data_in = data_in;

    sync_fifo_flags #(
        .data_width_p(8), .addr_size_p(3), .mem_depth_p(8),
        .afull_thresh_p(6), .aempty_thresh_p(1), .fwft_p(0)
    ) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sync_fifo_flags #(
        .data_width_p(8), .addr_size_p(3), .mem_depth_p(8),
        .afull_thresh_p(6), .aempty_thresh_p(1), .fwft_p(1)
    ) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            error_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given request; outputs are settled on return.
    task automatic step(input logic wr, input logic rd, input logic [7:0] din);
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    // {full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [5:0] flags_a();
        return {bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty,
                bus_a.overflow, bus_a.underflow};
    endfunction

    initial begin
        check_cnt = 0;
        error_cnt = 0;
        rst       = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        data_in   = 8'h00;
        #1 rst = 1'b1;
        #2;
        check_value("rst_count", 32'(bus_a.count), 32'd0);
        check_value("rst_flags", 32'(flags_a()), 32'b010100);
        check_value("rst_dout", 32'(bus_a.data_out), 32'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill with 0x10..0x17.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'h10 + i));
            check_value("fill_count", 32'(bus_a.count), 32'(i + 1));
            check_value("fill_flags", 32'(flags_a()),
                        32'({1'(i == 7), 1'b0, 1'(i >= 5), 1'(i == 0), 2'b00}));
        end
        step(1'b1, 1'b0, 8'h99);
        check_value("ovf_pulse", 32'(flags_a()), 32'b101010);
        check_value("ovf_count", 32'(bus_a.count), 32'd8);
        step(1'b0, 1'b0, 8'h00);
        check_value("ovf_clear", 32'(bus_a.overflow), 32'd0);

        // Drain in order.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check_value("drain_data", 32'(bus_a.data_out), 32'(8'h10 + i));
            check_value("drain_count", 32'(bus_a.count), 32'(7 - i));
            check_value("drain_flags", 32'(flags_a()),
                        32'({1'b0, 1'(i == 7), 1'(i < 2), 1'(i >= 6), 2'b00}));
        end
        step(1'b0, 1'b1, 8'h00);
        check_value("udf_pulse", 32'(flags_a()), 32'b010101);
        check_value("udf_hold", 32'(bus_a.data_out), 32'h17);
        step(1'b0, 1'b0, 8'h00);
        check_value("udf_clear", 32'(bus_a.underflow), 32'd0);
        check_value("udf_hold2", 32'(bus_a.data_out), 32'h17);

        // Streaming at count 3 across the pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        check_value("wrap_pre", 32'(bus_a.count), 32'd3);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'h23 + i));
            check_value("wrap_data", 32'(bus_a.data_out), 32'(8'h20 + i));
            check_value("wrap_count", 32'(bus_a.count), 32'd3);
            check_value("wrap_flags", 32'(flags_a()), 32'b000000);
        end

        // Simultaneous access at full: read wins, write rejected.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        check_value("full_count", 32'(bus_a.count), 32'd8);
        step(1'b1, 1'b1, 8'h77);
        check_value("full_rw_count", 32'(bus_a.count), 32'd7);
        check_value("full_rw_flags", 32'(flags_a()), 32'b001010);
        check_value("full_rw_data", 32'(bus_a.data_out), 32'h34);
        exp_q = '{8'h35, 8'h36, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check_value("post_full_data", 32'(bus_a.data_out), 32'(exp_q[i]));
        end
        check_value("post_full_empty", 32'(bus_a.empty), 32'd1);

        // Simultaneous access at empty: write wins, read rejected.
        step(1'b1, 1'b1, 8'h5A);
        check_value("empty_rw_count", 32'(bus_a.count), 32'd1);
        check_value("empty_rw_flags", 32'(flags_a()), 32'b000101);
        check_value("empty_rw_hold", 32'(bus_a.data_out), 32'h44);
        check_value("fwft_bypass", 32'(bus_b.data_out), 32'h5A);
        step(1'b0, 1'b1, 8'h00);
        check_value("empty_rw_data", 32'(bus_a.data_out), 32'h5A);
        check_value("empty_rw_drain", 32'(bus_a.count), 32'd0);

        // Asynchronous reset with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        check_value("mid_pre_count", 32'(bus_a.count), 32'd5);
        #2 rst = 1'b1;
        #1;
        check_value("mid_rst_count", 32'(bus_a.count), 32'd0);
        check_value("mid_rst_flags", 32'(flags_a()), 32'b010100);
        check_value("mid_rst_dout", 32'(bus_a.data_out), 32'h00);
        check_value("mid_rst_fwft", 32'({bus_b.count, bus_b.empty}), 32'b00001);
        @(posedge clk);
        #1 rst = 1'b0;
        check_value("mid_rel_flags", 32'(flags_a()), 32'b010100);
        step(1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b1, 8'h00);
        check_value("mid_post_data", 32'(bus_a.data_out), 32'h55);
        check_value("mid_post_count", 32'(bus_a.count), 32'd0);

        // First-word fall-through instance.
        step(1'b1, 1'b0, 8'hA5);
        check_value("fwft_first", 32'(bus_b.data_out), 32'hA5);
        check_value("fwft_nonempty", 32'(bus_b.empty), 32'd0);
        step(1'b1, 1'b0, 8'h3C);
        check_value("fwft_hold", 32'(bus_b.data_out), 32'hA5);
        check_value("fwft_count2", 32'(bus_b.count), 32'd2);
        step(1'b0, 1'b1, 8'h00);
        check_value("fwft_pop", 32'(bus_b.data_out), 32'h3C);
        check_value("fwft_count1", 32'(bus_b.count), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check_value("fwft_empty", 32'(bus_b.empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO; the same-clock-domain counterpart of the dual-clock FIFO.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the local buffer between datapath stages that share one clock, where no pointer synchronisers are needed.

Parameters:
- data_width_p, 8, width of each data word in bits.
- addr_size_p, 8, address width; the FIFO depth is 2**addr_size_p.
- mem_depth_p, 256, number of storage words; must equal 2**addr_size_p (elaboration error otherwise).
- afull_thresh_p, 252, almost_full asserts when count >= this value; legal range 1..mem_depth_p.
- aempty_thresh_p, 4, almost_empty asserts when count <= this value; legal range 0..mem_depth_p-1.
- fwft_p, 0, read mode: 0 = standard registered read, 1 = first-word fall-through.

Ports:
- clk, input, 1, the single clock; all state changes on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- wr_en, input, 1, write request.
- rd_en, input, 1, read request (in FWFT mode, this is the pop/acknowledge).
- data_in, input, data_width_p, write data.
- data_out, output, data_width_p, read data.
- full, output, 1, count == mem_depth_p.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= afull_thresh_p.
- almost_empty, output, 1, count <= aempty_thresh_p.
- count, output, addr_size_p+1, current number of stored words.
- overflow, output, 1, one-cycle pulse: a write was rejected.
- underflow, output, 1, one-cycle pulse: a read was rejected.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - Pointers = 0, count = 0, data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
- Reset mid-operation: all stored data is discarded, outputs return to their reset values, and no overflow/underflow pulse is generated.
- Pointers: binary, addr_size_p+1 bits. The lower addr_size_p bits address the memory; the MSB is a wrap bit. Wrap-around from mem_depth_p-1 to 0 is natural modulo.
- Accept conditions:
  - write accepted = wr_en & !full.
  - read accepted = rd_en & !empty.
  - Both use the registered flags from the current cycle.
- Simultaneous write and read:
  - Not full and not empty: both are accepted and count is unchanged.
  - At full: the read is accepted, the write is rejected, overflow pulses, and count becomes mem_depth_p-1.
  - At empty: the write is accepted, the read is rejected, underflow pulses, and count becomes 1.
- count update: count_next = count + wr_accept - rd_accept. All flags are registered and computed from count_next, so they are valid in the cycle after the causing edge; there is no combinational path from wr_en/rd_en to the flags.
- overflow / underflow:
  - overflow is registered, high for exactly one cycle after an edge where wr_en=1 and full=1.
  - underflow is registered, high for exactly one cycle after an edge where rd_en=1 and empty=1.
  - Neither pulse is sticky.
- Standard mode (fwft_p=0):
  - On an accepted read, data_out <= mem[rd_ptr]; data is valid one cycle after rd_en.
  - data_out holds its value when there is no accepted read.
- FWFT mode (fwft_p=1):
  - data_out = mem[rd_ptr] whenever empty=0, with no rd_en needed; rd_en advances to the next word.
  - Fall-through latency: a word written into an empty FIFO appears on data_out, with empty=0, one cycle after its write edge.
  - While empty=1, data_out is don't-care; the bench checks it only when empty=0.
- Memory write occurs on an accepted write at mem[wr_ptr[addr_size_p-1:0]]. No read-during-write hazard exists, because a read of the slot being written implies empty, which blocks the read.

Test Plan (addr_size_p=3, mem_depth_p=8, afull_thresh_p=6, aempty_thresh_p=1):
- Reset, then 8 writes of 0x10..0x17 with no reads:
  - count steps 1..8.
  - almost_empty deasserts after the 2nd write; almost_full asserts after the 6th; full asserts after the 8th.
  - A 9th write gives one overflow pulse and count stays 8.
- Then 8 reads (fwft_p=0):
  - data_out = 0x10..0x17, each one cycle after its rd_en.
  - empty asserts after the 8th read.
  - A 9th read gives one underflow pulse and data_out holds 0x17.
- Wrap-around: 20 cycles of continuous simultaneous write/read at count=3:
  - count stays 3, order is preserved across the pointer wrap, and no flag changes.
- Simultaneous wr_en/rd_en at full gives count 7 and an overflow pulse; at empty, count 1 and an underflow pulse.
- fwft_p=1:
  - Writing 0xA5 into an empty FIFO gives data_out=0xA5 and empty=0 on the next cycle, without rd_en.
  - Then writing 0x3C and popping once gives data_out=0x3C.
- Assert rst mid-stream with count=5:
  - All outputs go to reset values immediately, asynchronously.
  - After release, a write of 0x55 followed by a read returns 0x55, with no stale data.
